// File: rtl/signext_pkg.sv
// signext_pkg: shared definitions for the registered sign-extension pipe.
//   - MODE_* : 2-bit extension mode encodings carried on the mode input.
//   - state_e: occupancy of the output/skid register pair.
package signext_pkg;

  localparam logic [1:0] MODE_ZERO     = 2'b00;
  localparam logic [1:0] MODE_SIGN     = 2'b01;
  localparam logic [1:0] MODE_SIGN_SHL = 2'b10;
  localparam logic [1:0] MODE_ZERO_SHL = 2'b11;

  // EMPTY: nothing held; ONE: output register full; TWO: output and skid full.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // True for the modes that replicate the field MSB into the upper bits.
  function automatic logic mode_is_signed(input logic [1:0] mode);
    return (mode == MODE_SIGN) || (mode == MODE_SIGN_SHL);
  endfunction

  // True for the modes that apply the left shift after extension.
  function automatic logic mode_is_shift(input logic [1:0] mode);
    return (mode == MODE_SIGN_SHL) || (mode == MODE_ZERO_SHL);
  endfunction

endpackage

// File: rtl/signext_pipe_if.sv
// signext_pipe_if: upstream and downstream handshake bundle for signext_pipe.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. A producer holding valid must keep its payload stable until
// that edge; ready never depends combinationally on valid.
//
// Signals:
//   in_valid/in_ready/in_data/mode/shamt : upstream side (producer -> pipe)
//   out_valid/out_ready/out_data          : downstream side (pipe -> consumer)
//   busy                                  : pipe holds at least one word
// Modports:
//   master : the environment (drives inputs, consumes outputs)
//   slave  : the pipe itself
interface signext_pipe_if #(
  parameter int IN_W    = 2,
  parameter int OUT_W   = 8,
  parameter int SHAMT_W = 2
);
  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_data;
  logic [1:0]         mode;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic               busy;

  modport master (
    output in_valid, in_data, mode, shamt, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, mode, shamt, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/signext_core.sv
// signext_core: combinational extend-then-shift datapath.
//   data_i   [IN_W]    field to widen
//   mode_i   [2]       extension mode (see signext_pkg MODE_*)
//   shamt_i  [SHAMT_W] left-shift amount, used only by the shift modes
//   result_o [OUT_W]   extended (and possibly shifted) value
module signext_core
  import signext_pkg::*;
#(
  parameter int IN_W    = 2,
  parameter int OUT_W   = 8,
  parameter int SHAMT_W = 2
) (
  input  logic [IN_W-1:0]    data_i,
  input  logic [1:0]         mode_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [OUT_W-1:0]   result_o
);

  logic [OUT_W-1:0] ext_v;
  logic             fill_bit;

  always_comb begin
    ext_v           = '0;
    ext_v[IN_W-1:0] = data_i;
    fill_bit        = mode_is_signed(mode_i) & data_i[IN_W-1];
    // Loop form keeps the IN_W == OUT_W case legal (no zero-width replicate).
    for (int i = IN_W; i < OUT_W; i++) begin
      ext_v[i] = fill_bit;
    end
    // Logical shift inside OUT_W: overflowed bits drop, zeros enter.
    result_o = mode_is_shift(mode_i) ? (ext_v << shamt_i) : ext_v;
  end

endmodule

// File: rtl/signext_pipe.sv
// signext_pipe: registered sign/zero extender with a 2-entry skid buffer.
//
// Results are computed at the input side by signext_core, so both the output
// register (OR) and the skid register (SK) hold final values. in_ready is a
// function of the registered state only, giving full throughput without a
// combinational ready path from downstream to upstream.
//
// Ports:
//   Clk         clock, rising edge
//   Clear       synchronous active-high reset; drops any held words
//   bus         signext_pipe_if.slave handshake bundle
//   dbg_state_o current occupancy state (state_e)
//   neg_count   (only with SIGNEXT_STATS_EN) saturating count of accepted
//               signed-mode words whose field MSB was 1
//
// Build option: define SIGNEXT_STATS_EN to add the neg_count statistic.
module signext_pipe
  import signext_pkg::*;
#(
  parameter int IN_W    = 2,
  parameter int OUT_W   = 8,
  parameter int SHAMT_W = 2
) (
  input  logic                  Clk,
  input  logic                  Clear,
  signext_pipe_if.slave         bus,
`ifdef SIGNEXT_STATS_EN
  output logic [15:0]           neg_count,
`endif
  output state_e                dbg_state_o
);

  if (IN_W < 1) begin : g_bad_in_w
    $error("signext_pipe: IN_W must be at least 1");
  end
  if (OUT_W < IN_W) begin : g_bad_out_w
    $error("signext_pipe: OUT_W must not be smaller than IN_W");
  end

  state_e           state_q, state_d;
  logic [OUT_W-1:0] or_q, or_d;
  logic [OUT_W-1:0] sk_q, sk_d;
  logic [OUT_W-1:0] core_res;
  logic             accept;
  logic             xfer;

  signext_core #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .data_i   (bus.in_data),
    .mode_i   (bus.mode),
    .shamt_i  (bus.shamt),
    .result_o (core_res)
  );

  assign bus.in_ready  = (state_q != ST_TWO);
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.out_data  = or_q;
  assign bus.busy      = (state_q != ST_EMPTY);
  assign dbg_state_o   = state_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign xfer   = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    or_d    = or_q;
    sk_d    = sk_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          or_d    = core_res;
        end
      end
      ST_ONE: begin
        if (accept && xfer) begin
          // Old OR word leaves this edge, new word replaces it.
          or_d = core_res;
        end else if (accept) begin
          // OR is stalled: park the new word behind it.
          state_d = ST_TWO;
          sk_d    = core_res;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (xfer) begin
          state_d = ST_ONE;
          or_d    = sk_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clear) begin
      state_q <= ST_EMPTY;
      or_q    <= '0;
      sk_q    <= '0;
    end else begin
      state_q <= state_d;
      or_q    <= or_d;
      sk_q    <= sk_d;
    end
  end

`ifdef SIGNEXT_STATS_EN
  logic [15:0] neg_count_q;
  logic        neg_hit;

  assign neg_hit   = accept & mode_is_signed(bus.mode) & bus.in_data[IN_W-1];
  assign neg_count = neg_count_q;

  always_ff @(posedge Clk) begin
    if (Clear) begin
      neg_count_q <= '0;
    end else if (neg_hit && (neg_count_q != 16'hFFFF)) begin
      neg_count_q <= neg_count_q + 16'd1;
    end
  end
`endif

endmodule
